// File: rtl/video_scanout_if.sv
// Video port of the 8-bit computer: pixel pacing, character memory and glyph ROM buses.
interface video_scanout_if;
    logic        vid_phi;
    logic [15:0] vid_adr;
    logic [7:0]  vid_dbi;
    logic [9:0]  glyph_adr;
    logic [7:0]  glyph_dbi;

    // The raster generator owns the address buses; the host supplies pacing and read data.
    modport master (input vid_phi, input vid_dbi, input glyph_dbi, output vid_adr, output glyph_adr);
    modport slave  (output vid_phi, output vid_dbi, output glyph_dbi, input vid_adr, input glyph_adr);
endinterface

// File: rtl/video_scanout.sv
// Text-mode raster generator: VGA timing, character/glyph fetch and 1-bit pixel output.
//
// Every register advances only on vid_phi ticks. Each 16-tick cell is fetched three
// ticks ahead of display: T0 drives the character address, T1 latches the code and
// drives the glyph address, T2 loads the shifter so bit 7 is shown at the cell's first tick.
// Column 0 is fetched at the end of the previous line and therefore targets the next line.
module video_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          COLS     = 40,
    parameter int          ROWS     = 24,
    parameter logic [15:0] BASE_ADR = 16'h0400
) (
    input  logic            CLOCK_50,
    input  logic            res_n,
    video_scanout_if.master vid,
    output logic            pixel,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            blank
);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  H_COL0_T0  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 3);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  TEXT_LINES = 10'(ROWS * 16);
    localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
    localparam logic [15:0] COLS16     = 16'(COLS);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  v_next;
    logic [9:0]  f_vcnt;
    logic [5:0]  f_col;
    logic [15:0] f_adr;
    logic        col_ok;
    logic        fetch_t0;
    logic        t0_vld;
    logic        t1_vld;
    logic [2:0]  f_row;
    logic        code_inv;
    logic [7:0]  shifter;
    logic        text_area;

    assign v_next    = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    assign text_area = (hcnt < H_ACT) && (vcnt < TEXT_LINES);

    // Pick the cell targeted by a T0 fetch at this tick and decide whether it is in the text area.
    always_comb begin
        f_vcnt = vcnt;
        f_col  = hcnt[9:4] + 6'd1;
        col_ok = 1'b0;
        if (hcnt == H_COL0_T0) begin
            f_vcnt = v_next;
            f_col  = 6'd0;
            col_ok = 1'b1;
        end else begin
            col_ok = (hcnt[3:0] == 4'd13) && (hcnt[9:4] < LAST_COL);
        end
        fetch_t0 = col_ok && (f_vcnt < TEXT_LINES);
        f_adr    = BASE_ADR + {11'd0, f_vcnt[8:4]} * COLS16 + {10'd0, f_col};
    end

    // Raster counters: hcnt wraps per line, vcnt steps on each line wrap.
    always_ff @(posedge CLOCK_50) begin
        if (!res_n) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else if (vid.vid_phi) begin
            if (hcnt == H_LAST) begin
                hcnt <= 10'd0;
                vcnt <= v_next;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // T0/T1 fetch stages: character address, then glyph address from the returned code.
    always_ff @(posedge CLOCK_50) begin
        if (!res_n) begin
            t0_vld        <= 1'b0;
            t1_vld        <= 1'b0;
            f_row         <= 3'd0;
            code_inv      <= 1'b0;
            vid.vid_adr   <= BASE_ADR;
            vid.glyph_adr <= 10'd0;
        end else if (vid.vid_phi) begin
            t0_vld <= fetch_t0;
            t1_vld <= t0_vld;
            if (fetch_t0) begin
                vid.vid_adr <= f_adr;
                f_row       <= f_vcnt[3:1];
            end
            if (t0_vld) begin
                code_inv      <= vid.vid_dbi[7];
                vid.glyph_adr <= {vid.vid_dbi[6:0], f_row};
            end
        end
    end

    // T2 load at the last tick of the previous cell; otherwise shift once per two ticks.
    always_ff @(posedge CLOCK_50) begin
        if (!res_n) begin
            shifter <= 8'd0;
        end else if (vid.vid_phi) begin
            if (hcnt[3:0] == 4'd15) begin
                shifter <= t1_vld ? (vid.glyph_dbi ^ {8{code_inv}}) : 8'd0;
            end else if (hcnt[0]) begin
                shifter <= {shifter[6:0], 1'b0};
            end
        end
    end

    // Registered outputs, all reflecting the same tick so pixel and syncs stay aligned.
    always_ff @(posedge CLOCK_50) begin
        if (!res_n) begin
            pixel   <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            blank   <= 1'b1;
        end else if (vid.vid_phi) begin
            pixel   <= text_area && shifter[7];
            hsync_n <= !((hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END));
            vsync_n <= !((vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END));
            blank   <= (hcnt >= H_ACT) || (vcnt >= V_ACT);
        end
    end
endmodule
